// File: rtl/count_monitor.sv
// ---------------------------------------------------------------------------
// count_monitor
//
// Downstream checker for a WIDTH-bit synchronous up-counter. Every rising
// edge it compares the counter output against the value predicted from the
// previous sample. The prediction is the previous value plus one when
// counting was enabled, and the previous value otherwise. From these checks
// the monitor acquires lock, reports and counts wrap-arounds, and flags and
// counts sequence errors.
//
// Parameters
//   WIDTH   width of the monitored count
//   LOCK_N  consecutive good checks needed to (re)enter lock, 1..15
//   WRAP_W  width of the wrap counter
//
// Ports
//   clk       in   rising-edge clock, shared with the counter
//   clear     in   synchronous active-high reset
//   cnt_en    in   counter enable seen by the counter on this edge
//   q         in   counter output Q
//   locked    out  sequence tracked and correct
//   err       out  sticky error flag, set on the first error while locked
//   err_cnt   out  errors seen in LOCK/FAULT, saturating at 255
//   tc        out  one-cycle pulse per observed all-ones -> 0 wrap in LOCK
//   wrap_cnt  out  number of tc pulses, modulo 2^WRAP_W
// ---------------------------------------------------------------------------
module count_monitor #(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 2,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cnt_en,
  input  logic [WIDTH-1:0]  q,
  output logic              locked,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [3:0]       LOCK_N_C = 4'(LOCK_N);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [7:0]       ERR_MAX  = 8'hFF;

  // Registered state and outputs
  state_t              state_q;
  logic [WIDTH-1:0]    q_prev_q;
  logic                en_q;
  logic [3:0]          good_cnt_q;
  logic                locked_q;
  logic                err_q;
  logic [7:0]          err_cnt_q;
  logic                tc_q;
  logic [WRAP_W-1:0]   wrap_cnt_q;

  // Combinational helpers (next values of the counters, check results)
  logic [WIDTH-1:0]    exp_val;
  logic                match;
  logic                wrap_hit;
  logic [3:0]          good_cnt_d;
  logic                good_reach;
  logic [7:0]          err_cnt_d;
  logic [WRAP_W-1:0]   wrap_cnt_d;

  always_comb begin
    exp_val    = en_q ? (q_prev_q + WIDTH'(1)) : q_prev_q;
    match      = (q == exp_val);
    // A wrap is only a wrap if the counter was actually told to advance.
    wrap_hit   = en_q && (q_prev_q == ALL_ONES) && (q == '0);
    good_cnt_d = good_cnt_q + 4'd1;
    good_reach = (good_cnt_d == LOCK_N_C);
    // Error counter sticks at its maximum instead of rolling over.
    err_cnt_d  = (err_cnt_q == ERR_MAX) ? err_cnt_q : (err_cnt_q + 8'd1);
    wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= ST_SYNC;
      q_prev_q   <= '0;
      en_q       <= 1'b0;
      good_cnt_q <= 4'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      tc_q       <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      // The history registers track the counter on every edge, whatever
      // the state, so the next check always compares adjacent samples.
      q_prev_q <= q;
      en_q     <= cnt_en;
      tc_q     <= 1'b0;

      case (state_q)
        ST_SYNC: begin
          // No valid history yet; this edge only captures q_prev / en_d.
          state_q <= ST_ACQ;
        end

        ST_ACQ: begin
          if (match) begin
            if (good_reach) begin
              state_q    <= ST_LOCK;
              locked_q   <= 1'b1;
              good_cnt_q <= 4'd0;
            end else begin
              good_cnt_q <= good_cnt_d;
            end
          end else begin
            // Mismatches before first lock are just start-up noise.
            good_cnt_q <= 4'd0;
          end
        end

        ST_LOCK: begin
          if (match) begin
            if (wrap_hit) begin
              tc_q       <= 1'b1;
              wrap_cnt_q <= wrap_cnt_d;
            end
          end else begin
            // A mismatch overrides a coincident wrap pattern.
            state_q    <= ST_FAULT;
            locked_q   <= 1'b0;
            err_q      <= 1'b1;
            err_cnt_q  <= err_cnt_d;
            good_cnt_q <= 4'd0;
          end
        end

        ST_FAULT: begin
          // Wraps are not reported here: the sequence is not trusted.
          if (match) begin
            if (good_reach) begin
              state_q    <= ST_LOCK;
              locked_q   <= 1'b1;
              good_cnt_q <= 4'd0;
            end else begin
              good_cnt_q <= good_cnt_d;
            end
          end else begin
            err_cnt_q  <= err_cnt_d;
            good_cnt_q <= 4'd0;
          end
        end

        default: begin
          state_q <= ST_SYNC;
        end
      endcase
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign tc       = tc_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule
